// File: rtl/pla_plane_pipe.sv
// Two-stage programmable AND/OR plane behind a valid/ready stream.
// Stage 1 latches per-term cube hits; stage 2 applies the OR masks and presents the result.
module pla_plane_pipe #(
  parameter int N_IN    = 15,
  parameter int N_TERMS = 8,
  parameter int N_OUT   = 1,
  parameter int TW      = $clog2(N_TERMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_y,
  output logic [N_TERMS-1:0] out_hit,
  input  logic               cfg_we,
  input  logic [TW-1:0]      cfg_term,
  input  logic               cfg_en,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic [N_OUT-1:0]   cfg_or
);

  logic              en_q   [N_TERMS];
  logic              en_d   [N_TERMS];
  logic [N_IN-1:0]   care_q [N_TERMS];
  logic [N_IN-1:0]   care_d [N_TERMS];
  logic [N_IN-1:0]   val_q  [N_TERMS];
  logic [N_IN-1:0]   val_d  [N_TERMS];
  logic [N_OUT-1:0]  or_q   [N_TERMS];
  logic [N_OUT-1:0]  or_d   [N_TERMS];

  logic [N_TERMS-1:0] hit_comb;

  logic               s1_valid_q, s1_valid_d;
  logic [N_TERMS-1:0] s1_hit_q, s1_hit_d;
  logic               s2_valid_q, s2_valid_d;
  logic [N_OUT-1:0]   out_y_q, out_y_d;
  logic [N_TERMS-1:0] out_hit_q, out_hit_d;
  logic [N_OUT-1:0]   y_comb;

  logic accept;
  logic s2_load;

  genvar gi;
  generate
    for (gi = 0; gi < N_TERMS; gi++) begin : g_term
      // Matching by equality means out-of-range indices select no entry at all.
      always_comb begin
        en_d[gi]   = en_q[gi];
        care_d[gi] = care_q[gi];
        val_d[gi]  = val_q[gi];
        or_d[gi]   = or_q[gi];
        if (cfg_we && (32'(cfg_term) == gi)) begin
          en_d[gi]   = cfg_en;
          care_d[gi] = cfg_care;
          val_d[gi]  = cfg_val;
          or_d[gi]   = cfg_or;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          en_q[gi]   <= 1'b0;
          care_q[gi] <= '0;
          val_q[gi]  <= '0;
          or_q[gi]   <= '0;
        end else begin
          en_q[gi]   <= en_d[gi];
          care_q[gi] <= care_d[gi];
          val_q[gi]  <= val_d[gi];
          or_q[gi]   <= or_d[gi];
        end
      end

      assign hit_comb[gi] = en_q[gi] && (((in_x ^ val_q[gi]) & care_q[gi]) == '0);
    end
  endgenerate

  assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);

  always_comb begin
    y_comb = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (s1_hit_q[t]) y_comb = y_comb | or_q[t];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_hit_d   = s1_hit_q;
    s2_valid_d = s2_valid_q;
    out_y_d    = out_y_q;
    out_hit_d  = out_hit_q;
    // Accepting while stage 1 is full only happens when stage 1 drains this cycle.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_hit_d   = hit_comb;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = 1'b1;
      out_y_d    = y_comb;
      out_hit_d  = s1_hit_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      s2_valid_q <= 1'b0;
      out_y_q    <= '0;
      out_hit_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hit_q   <= s1_hit_d;
      s2_valid_q <= s2_valid_d;
      out_y_q    <= out_y_d;
      out_hit_q  <= out_hit_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = out_y_q;
  assign out_hit   = out_hit_q;

endmodule

// File: tb/tb_pla_plane_pipe.sv
// Directed bench for pla_plane_pipe: cube programming, latency, backpressure,
// config/accept overlap, mid-stream reset and out-of-range config index.
module tb_pla_plane_pipe;

  localparam int N_IN    = 15;
  localparam int N_TERMS = 8;
  localparam int N_OUT   = 1;
  localparam int TW      = 4;  // wide enough to express index N_TERMS

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N_IN-1:0]    in_x;
  logic               out_valid;
  logic               out_ready;
  logic [N_OUT-1:0]   out_y;
  logic [N_TERMS-1:0] out_hit;
  logic               cfg_we;
  logic [TW-1:0]      cfg_term;
  logic               cfg_en;
  logic [N_IN-1:0]    cfg_care;
  logic [N_IN-1:0]    cfg_val;
  logic [N_OUT-1:0]   cfg_or;

  int n_checks = 0;
  int n_fail   = 0;

  pla_plane_pipe #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_hit(out_hit),
    .cfg_we(cfg_we), .cfg_term(cfg_term), .cfg_en(cfg_en),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_or(cfg_or)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [TW-1:0] t, input logic en, input logic [N_IN-1:0] care,
                           input logic [N_IN-1:0] val, input logic [N_OUT-1:0] orm);
    cfg_we = 1'b1; cfg_term = t; cfg_en = en; cfg_care = care; cfg_val = val; cfg_or = orm;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic program_plane();
    cfg_write(4'd0, 1'b1, 15'h7FFF, 15'h0004, 1'b1);
    cfg_write(4'd1, 1'b1, 15'h7FFF, 15'h0100, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (out_y !== '0) begin n_fail++; $display("FAIL reset_out_y got=%h exp=0", out_y); end
    n_checks++;
    if (out_hit !== '0) begin n_fail++; $display("FAIL reset_out_hit got=%h exp=00", out_hit); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    $display("reset: out_valid=%b out_y=%h out_hit=%h in_ready=%b", out_valid, out_y, out_hit, in_ready);
  endtask

  // Single sample through an all-disabled plane.
  task automatic test_powerup();
    for (int cyc = 0; cyc < 3; cyc++) begin
      in_valid = (cyc == 0);
      in_x = 15'h7FFF;
      #1;
      n_checks++;
      if (out_valid !== (cyc == 2)) begin
        n_fail++; $display("FAIL powerup_valid cyc=%0d got=%b exp=%b", cyc, out_valid, cyc == 2);
      end
      if (cyc == 2) begin
        n_checks++;
        if (out_y !== 1'b0 || out_hit !== 8'h00) begin
          n_fail++; $display("FAIL powerup_result got y=%h hit=%h exp y=0 hit=00", out_y, out_hit);
        end
        $display("powerup: x=7fff y=%h hit=%h", out_y, out_hit);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic(input string tag);
    logic [N_IN-1:0]    vin  [4] = '{15'h0004, 15'h0100, 15'h0104, 15'h0000};
    logic [N_OUT-1:0]   yexp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [N_TERMS-1:0] hexp [4] = '{8'h01, 8'h02, 8'h00, 8'h00};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (cyc < 4);
      in_x = (cyc < 4) ? vin[cyc] : '0;
      #1;
      if (cyc < 4) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready cyc=%0d got=%b exp=1", tag, cyc, in_ready); end
      end
      n_checks++;
      if (out_valid !== (cyc >= 2)) begin
        n_fail++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", tag, cyc, out_valid, cyc >= 2);
      end
      if (cyc >= 2) begin
        n_checks++;
        if (out_y !== yexp[cyc-2] || out_hit !== hexp[cyc-2]) begin
          n_fail++;
          $display("FAIL %s_result idx=%0d got y=%h hit=%h exp y=%h hit=%h",
                   tag, cyc - 2, out_y, out_hit, yexp[cyc-2], hexp[cyc-2]);
        end
        $display("%s: x=%h y=%h hit=%h", tag, vin[cyc-2], out_y, out_hit);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N_IN-1:0]    vin  [4] = '{15'h0004, 15'h0100, 15'h0104, 15'h0004};
    logic [N_OUT-1:0]   yexp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [N_TERMS-1:0] hexp [4] = '{8'h01, 8'h02, 8'h00, 8'h01};
    int si = 0;
    int oi = 0;
    logic fire_in, fire_out;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (si < 4);
      in_x = (si < 4) ? vin[si] : '0;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 1'b1 || out_hit !== 8'h01) begin
          n_fail++;
          $display("FAIL bp_stall cyc=%0d got in_ready=%b valid=%b y=%h hit=%h exp 0 1 1 01",
                   cyc, in_ready, out_valid, out_y, out_hit);
        end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        n_checks++;
        if (oi >= 4) begin
          n_fail++; $display("FAIL bp_extra_output got y=%h hit=%h exp none", out_y, out_hit);
        end else begin
          if (out_y !== yexp[oi] || out_hit !== hexp[oi]) begin
            n_fail++;
            $display("FAIL bp_result idx=%0d got y=%h hit=%h exp y=%h hit=%h",
                     oi, out_y, out_hit, yexp[oi], hexp[oi]);
          end
          $display("bp: idx=%0d x=%h y=%h hit=%h", oi, vin[oi], out_y, out_hit);
        end
        oi++;
      end
      step();
      if (fire_in) si++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (si !== 4 || oi !== 4) begin
      n_fail++; $display("FAIL bp_count got accepted=%0d delivered=%0d exp 4 4", si, oi);
    end
  endtask

  // Entry write overlapping an accept must not affect that sample.
  task automatic test_cfg_same_cycle();
    logic [N_IN-1:0]    vin  [3] = '{15'h0004, 15'h0004, 15'h0005};
    logic [N_OUT-1:0]   yexp [3] = '{1'b1, 1'b0, 1'b1};
    logic [N_TERMS-1:0] hexp [3] = '{8'h01, 8'h00, 8'h01};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (cyc < 3);
      in_x = (cyc < 3) ? vin[cyc] : '0;
      cfg_we = (cyc == 0);
      cfg_term = 4'd0; cfg_en = 1'b1; cfg_care = 15'h7FFF; cfg_val = 15'h0005; cfg_or = 1'b1;
      #1;
      if (cyc >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== yexp[cyc-2] || out_hit !== hexp[cyc-2]) begin
          n_fail++;
          $display("FAIL cfgsame_result idx=%0d got valid=%b y=%h hit=%h exp valid=1 y=%h hit=%h",
                   cyc - 2, out_valid, out_y, out_hit, yexp[cyc-2], hexp[cyc-2]);
        end
        $display("cfgsame: x=%h y=%h hit=%h", vin[cyc-2], out_y, out_hit);
      end
      step();
    end
    cfg_we = 1'b0;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_rst_midstream();
    cfg_write(4'd0, 1'b1, 15'h7FFF, 15'h0004, 1'b1);
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      in_valid = 1'b1;
      in_x = 15'h0004;
      step();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_full got in_ready=%b valid=%b y=%h exp 0 1 1", in_ready, out_valid, out_y);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_after got valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      in_valid = (cyc == 0);
      in_x = 15'h0004;
      #1;
      n_checks++;
      if (out_valid !== (cyc == 2)) begin
        n_fail++; $display("FAIL rstmid_valid cyc=%0d got=%b exp=%b", cyc, out_valid, cyc == 2);
      end
      if (cyc == 2) begin
        n_checks++;
        if (out_y !== 1'b0 || out_hit !== 8'h00) begin
          n_fail++; $display("FAIL rstmid_cleared got y=%h hit=%h exp y=0 hit=00", out_y, out_hit);
        end
        $display("rstmid: x=0004 y=%h hit=%h", out_y, out_hit);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bad_index();
    do_reset();
    program_plane();
    // A catch-all term; if aliased onto an entry every sample would hit.
    cfg_write(4'd8, 1'b1, 15'h0000, 15'h0000, 1'b1);
    step();
    test_basic("badidx");
  endtask

  initial begin
    do_reset();
    test_reset();
    test_powerup();
    program_plane();
    test_basic("basic");
    test_backpressure();
    test_cfg_same_cycle();
    test_rst_midstream();
    test_bad_index();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
